uart_device_fifo: RTL

//  Parametrised next-generation register-mapped UART: full-duplex TX/RX with per-direction FIFOs,

---
 rtl/uart_device_fifo.sv | 311 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_device_fifo.sv
// uart_device_fifo: register-mapped full-duplex UART with TX/RX FIFOs, runtime baud divider,
// optional parity, sticky error flags and maskable interrupt. Build option: UART_LOOPBACK_EN.

module uart_device_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic         pop_s;
  logic         push_s;

  // A full FIFO still accepts a push when the same cycle pops an entry.
  assign empty  = (wr_ptr_r == rd_ptr_r);
  assign full   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s  = pop & ~empty;
  assign push_s = push & (~full | pop_s);
  assign drop   = push & ~push_s;
  assign dout   = mem_r[rd_ptr_r[AW-1:0]];

  // storage write port
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

  // read/write pointers
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end
endmodule

module uart_device_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int DIV_RST    = 433,
  localparam int BW        = (DATA_BITS > 16) ? DATA_BITS : 16
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          ce,
  input  logic          we,
  input  logic [1:0]    adr,
  input  logic [BW-1:0] wdat,
  output logic [BW-1:0] rdat,
  input  logic          rx,
  output logic          tx,
  output logic          inter,
  input  logic          dis_int
);
`ifdef UART_LOOPBACK_EN
  localparam logic [5:0] CTRL_MASK = 6'h3F;
`else
  localparam logic [5:0] CTRL_MASK = 6'h1F;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic                 rd_s, wr_s, stat_clr_s;
  logic [5:0]           ctrl_r;
  logic [DIV_W-1:0]     baud_r;
  logic                 rx_overrun_r, frame_err_r, parity_err_r, tx_drop_r;
  logic [7:0]           status_s;
  logic                 tx_empty_s, tx_full_s, tx_drop_s, tx_pop_s;
  logic [DATA_BITS-1:0] tx_dout_s;
  logic                 rx_empty_s, rx_full_s, rx_drop_s, rx_pop_s;
  logic [DATA_BITS-1:0] rx_dout_s;

  state_t               tx_state_r;
  logic [DIV_W-1:0]     tx_div_r, tx_cnt_r;
  logic [DATA_BITS-1:0] tx_shift_r;
  logic [3:0]           tx_bit_r;
  logic                 tx_par_en_r, tx_par_r, tx_line_r;

  state_t               rx_state_r;
  logic                 rx_src_s, rx_s1_r, rx_s2_r, rx_armed_r;
  logic [DIV_W-1:0]     rx_div_r, rx_cnt_r;
  logic [DATA_BITS-1:0] rx_shift_r;
  logic [3:0]           rx_bit_r;
  logic                 rx_par_en_r, rx_par_odd_r, rx_par_bad_r;
  logic                 rx_push_r, rx_frame_evt_r, rx_par_evt_r;

  assign rd_s       = ce & ~we;
  assign wr_s       = ce & we;
  assign stat_clr_s = rd_s & (adr == 2'd1);
  assign rx_pop_s   = rd_s & (adr == 2'd0) & ~rx_empty_s;
  assign status_s   = {tx_drop_r, parity_err_r, frame_err_r, rx_overrun_r,
                       tx_full_s, tx_empty_s, rx_full_s, rx_empty_s};

`ifdef UART_LOOPBACK_EN
  assign rx_src_s = ctrl_r[5] ? tx_line_r : rx;
  assign tx       = tx_line_r | ctrl_r[5];
`else
  assign rx_src_s = rx;
  assign tx       = tx_line_r;
`endif

  uart_device_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .arst(arst), .push(wr_s & (adr == 2'd0)), .pop(tx_pop_s),
    .din(wdat[DATA_BITS-1:0]), .dout(tx_dout_s), .empty(tx_empty_s), .full(tx_full_s),
    .drop(tx_drop_s)
  );

  uart_device_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .arst(arst), .push(rx_push_r), .pop(rx_pop_s),
    .din(rx_shift_r), .dout(rx_dout_s), .empty(rx_empty_s), .full(rx_full_s),
    .drop(rx_drop_s)
  );

  // bus register file, sticky flags (set beats clear), read data and interrupt
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      ctrl_r       <= 6'd0;
      baud_r       <= DIV_W'(DIV_RST);
      rdat         <= '0;
      rx_overrun_r <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      tx_drop_r    <= 1'b0;
      inter        <= 1'b0;
    end else begin
      if (wr_s && adr == 2'd2) ctrl_r <= wdat[5:0] & CTRL_MASK;
      if (wr_s && adr == 2'd3) baud_r <= wdat[DIV_W-1:0];
      if (rd_s) begin
        case (adr)
          2'd0:    rdat <= rx_empty_s ? '0 : BW'(rx_dout_s);
          2'd1:    rdat <= BW'(status_s);
          2'd2:    rdat <= BW'(ctrl_r);
          2'd3:    rdat <= BW'(baud_r);
          default: rdat <= '0;
        endcase
      end
      rx_overrun_r <= (rx_overrun_r & ~stat_clr_s) | rx_drop_s;
      frame_err_r  <= (frame_err_r  & ~stat_clr_s) | rx_frame_evt_r;
      parity_err_r <= (parity_err_r & ~stat_clr_s) | rx_par_evt_r;
      tx_drop_r    <= (tx_drop_r    & ~stat_clr_s) | tx_drop_s;
      inter        <= ~dis_int & ((ctrl_r[0] & ~rx_empty_s) | (ctrl_r[1] & tx_empty_s) |
                                  (ctrl_r[2] & (|status_s[7:4])));
    end
  end

  // A new frame starts straight from IDLE or from the last STOP clock, so frames run gap-free.
  assign tx_pop_s = ~tx_empty_s & ((tx_state_r == S_IDLE) ||
                                   (tx_state_r == S_STOP && tx_cnt_r == tx_div_r));

  // transmit framing
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      tx_state_r  <= S_IDLE;
      tx_div_r    <= '0;
      tx_cnt_r    <= '0;
      tx_shift_r  <= '0;
      tx_bit_r    <= 4'd0;
      tx_par_en_r <= 1'b0;
      tx_par_r    <= 1'b0;
      tx_line_r   <= 1'b1;
    end else if (tx_pop_s) begin
      tx_state_r  <= S_START;
      tx_line_r   <= 1'b0;
      tx_cnt_r    <= '0;
      tx_bit_r    <= 4'd0;
      tx_shift_r  <= tx_dout_s;
      tx_div_r    <= baud_r;
      tx_par_en_r <= ctrl_r[3];
      tx_par_r    <= parity_bit(tx_dout_s, ctrl_r[4]);
    end else if (tx_state_r != S_IDLE && tx_cnt_r != tx_div_r) begin
      tx_cnt_r <= tx_cnt_r + DIV_W'(1);
    end else begin
      tx_cnt_r <= '0;
      case (tx_state_r)
        S_IDLE: tx_line_r <= 1'b1;
        S_START: begin
          tx_state_r <= S_DATA;
          tx_line_r  <= tx_shift_r[0];
        end
        S_DATA: begin
          if (tx_bit_r == 4'(DATA_BITS - 1)) begin
            tx_state_r <= tx_par_en_r ? S_PARITY : S_STOP;
            tx_line_r  <= tx_par_en_r ? tx_par_r : 1'b1;
          end else begin
            tx_bit_r   <= tx_bit_r + 4'd1;
            tx_shift_r <= tx_shift_r >> 1;
            tx_line_r  <= tx_shift_r[1];
          end
        end
        S_PARITY: begin
          tx_state_r <= S_STOP;
          tx_line_r  <= 1'b1;
        end
        default: begin
          tx_state_r <= S_IDLE;
          tx_line_r  <= 1'b1;
        end
      endcase
    end
  end

  // two-flop synchroniser for the asynchronous serial input
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      rx_s1_r <= 1'b1;
      rx_s2_r <= 1'b1;
    end else begin
      rx_s1_r <= rx_src_s;
      rx_s2_r <= rx_s1_r;
    end
  end

  // receive framing; a good stop bit re-arms at once, a low one waits for the line to rise
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      rx_state_r     <= S_IDLE;
      rx_armed_r     <= 1'b0;
      rx_div_r       <= '0;
      rx_cnt_r       <= '0;
      rx_shift_r     <= '0;
      rx_bit_r       <= 4'd0;
      rx_par_en_r    <= 1'b0;
      rx_par_odd_r   <= 1'b0;
      rx_par_bad_r   <= 1'b0;
      rx_push_r      <= 1'b0;
      rx_frame_evt_r <= 1'b0;
      rx_par_evt_r   <= 1'b0;
    end else begin
      rx_push_r      <= 1'b0;
      rx_frame_evt_r <= 1'b0;
      rx_par_evt_r   <= 1'b0;
      case (rx_state_r)
        S_IDLE: begin
          rx_cnt_r <= '0;
          rx_bit_r <= 4'd0;
          if (rx_armed_r && !rx_s2_r) begin
            rx_state_r   <= S_START;
            rx_div_r     <= baud_r;
            rx_par_en_r  <= ctrl_r[3];
            rx_par_odd_r <= ctrl_r[4];
            rx_par_bad_r <= 1'b0;
          end else if (rx_s2_r) begin
            rx_armed_r <= 1'b1;
          end
        end
        S_START: begin
          if (rx_cnt_r == (rx_div_r >> 1)) begin
            rx_cnt_r   <= '0;
            rx_state_r <= rx_s2_r ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r + DIV_W'(1);
          end
        end
        S_DATA: begin
          if (rx_cnt_r == rx_div_r) begin
            rx_cnt_r   <= '0;
            rx_shift_r <= {rx_s2_r, rx_shift_r[DATA_BITS-1:1]};
            if (rx_bit_r == 4'(DATA_BITS - 1)) begin
              rx_state_r <= rx_par_en_r ? S_PARITY : S_STOP;
            end else begin
              rx_bit_r <= rx_bit_r + 4'd1;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + DIV_W'(1);
          end
        end
        S_PARITY: begin
          if (rx_cnt_r == rx_div_r) begin
            rx_cnt_r     <= '0;
            rx_par_bad_r <= rx_s2_r ^ parity_bit(rx_shift_r, rx_par_odd_r);
            rx_state_r   <= S_STOP;
          end else begin
            rx_cnt_r <= rx_cnt_r + DIV_W'(1);
          end
        end
        S_STOP: begin
          if (rx_cnt_r == rx_div_r) begin
            rx_cnt_r       <= '0;
            rx_state_r     <= S_IDLE;
            rx_armed_r     <= rx_s2_r;
            rx_push_r      <= 1'b1;
            rx_frame_evt_r <= ~rx_s2_r;
            rx_par_evt_r   <= rx_par_bad_r;
          end else begin
            rx_cnt_r <= rx_cnt_r + DIV_W'(1);
          end
        end
        default: rx_state_r <= S_IDLE;
      endcase
    end
  end
endmodule
